// File: rtl/npu_inst_dispatcher_if.sv
// Dispatcher bus: instruction intake from the look-ahead buffer, per-unit
// issue (instruction + enable pulse), unit busy feedback, sync and error status.
interface npu_inst_dispatcher_if #(
    parameter int INST_W = 32
);
    logic              enable_i;
    logic [INST_W-1:0] inst_i;
    logic              inst_valid_i;
    logic              inst_busy_o;

    logic [INST_W-1:0] weight_inst_o;
    logic [INST_W-1:0] matmul_inst_o;
    logic [INST_W-1:0] act_inst_o;
    logic              weight_en_o;
    logic              matmul_en_o;
    logic              act_en_o;
    logic              weight_busy_i;
    logic              matmul_busy_i;
    logic              act_busy_i;

    logic              sync_o;
    logic [1:0]        error_o;

    // dispatcher side
    modport master (
        input  enable_i, inst_i, inst_valid_i,
        input  weight_busy_i, matmul_busy_i, act_busy_i,
        output inst_busy_o,
        output weight_inst_o, matmul_inst_o, act_inst_o,
        output weight_en_o, matmul_en_o, act_en_o,
        output sync_o, error_o
    );

    // instruction source / execution units side
    modport slave (
        output enable_i, inst_i, inst_valid_i,
        output weight_busy_i, matmul_busy_i, act_busy_i,
        input  inst_busy_o,
        input  weight_inst_o, matmul_inst_o, act_inst_o,
        input  weight_en_o, matmul_en_o, act_en_o,
        input  sync_o, error_o
    );
endinterface

// File: rtl/npu_inst_dispatcher.sv
// NPU instruction dispatcher. A WEIGHT load is parked in a pending slot so it
// can be issued together with the MATMUL/ACT that follows it; other work is
// held until its unit group is ready. SYNC drains all units with a timeout.
module npu_inst_dispatcher #(
    parameter int SYNC_TIMEOUT = 1023,
    parameter int INST_W       = 32
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    npu_inst_dispatcher_if.master bus
);
    localparam int OP_CODE_WIDTH = 8;
    localparam int CNT_W         = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WEIGHT_PEND, HOLD, SYNC_WAIT} state_t;
    typedef enum logic [2:0] {K_NOP, K_WGT, K_MM, K_ACT, K_SYNC, K_ILL} kind_t;

    state_t            state;
    kind_t             in_kind;
    kind_t             held_kind;
    logic [INST_W-1:0] w_slot;
    logic              w_vld;
    logic [INST_W-1:0] h_slot;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        err;
    logic              weight_en, matmul_en, act_en, sync_pls;
    logic [INST_W-1:0] weight_inst, matmul_inst, act_inst;
    logic              w_ok, x_ok, grp_ready, units_idle;

    // classify the incoming opcode
    always_comb begin
        case (bus.inst_i[OP_CODE_WIDTH-1:3])
            5'b00000: in_kind = K_NOP;
            5'b00001: in_kind = K_WGT;
            5'b00010: in_kind = K_MM;
            5'b00100: in_kind = K_ACT;
            5'b11111: in_kind = K_SYNC;
            default:  in_kind = K_ILL;
        endcase
    end

    // MATMUL and ACT share the datapath, so either one waits for both units
    assign w_ok       = !w_vld || !bus.weight_busy_i;
    assign x_ok       = (held_kind inside {K_MM, K_ACT}) ?
                        !(bus.matmul_busy_i || bus.act_busy_i) : 1'b1;
    assign grp_ready  = w_ok && x_ok;
    assign units_idle = !(bus.weight_busy_i || bus.matmul_busy_i || bus.act_busy_i);

    // dispatcher FSM; all issue outputs are registered here
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state       <= IDLE;
            held_kind   <= K_NOP;
            w_slot      <= '0;
            w_vld       <= 1'b0;
            h_slot      <= '0;
            cnt         <= '0;
            err         <= 2'b00;
            weight_en   <= 1'b0;
            matmul_en   <= 1'b0;
            act_en      <= 1'b0;
            sync_pls    <= 1'b0;
            weight_inst <= '0;
            matmul_inst <= '0;
            act_inst    <= '0;
        end else if (!bus.enable_i) begin
            // frozen: only the single-cycle pulses are dropped
            weight_en <= 1'b0;
            matmul_en <= 1'b0;
            act_en    <= 1'b0;
            sync_pls  <= 1'b0;
        end else begin
            weight_en <= 1'b0;
            matmul_en <= 1'b0;
            act_en    <= 1'b0;
            sync_pls  <= 1'b0;
            case (state)
                IDLE, WEIGHT_PEND: begin
                    if (bus.inst_valid_i) begin
                        case (in_kind)
                            K_NOP: ;
                            K_ILL: err[0] <= 1'b1;
                            K_WGT: begin
                                if (state == IDLE) begin
                                    w_slot <= bus.inst_i;
                                    w_vld  <= 1'b1;
                                    state  <= WEIGHT_PEND;
                                end else begin
                                    h_slot    <= bus.inst_i;
                                    held_kind <= K_WGT;
                                    state     <= HOLD;
                                end
                            end
                            default: begin
                                h_slot    <= bus.inst_i;
                                held_kind <= in_kind;
                                state     <= HOLD;
                            end
                        endcase
                    end
                end
                HOLD: begin
                    if (held_kind == K_SYNC && !w_vld) begin
                        cnt   <= '0;
                        state <= SYNC_WAIT;
                    end else if (grp_ready) begin
                        if (w_vld) begin
                            weight_en   <= 1'b1;
                            weight_inst <= w_slot;
                            w_vld       <= 1'b0;
                        end
                        case (held_kind)
                            K_MM: begin
                                matmul_en   <= 1'b1;
                                matmul_inst <= h_slot;
                                state       <= IDLE;
                            end
                            K_ACT: begin
                                act_en   <= 1'b1;
                                act_inst <= h_slot;
                                state    <= IDLE;
                            end
                            K_SYNC: begin
                                cnt   <= '0;
                                state <= SYNC_WAIT;
                            end
                            default: begin
                                // held WEIGHT takes over the pending slot
                                w_slot <= h_slot;
                                w_vld  <= 1'b1;
                                state  <= WEIGHT_PEND;
                            end
                        endcase
                    end
                end
                SYNC_WAIT: begin
                    // the entry cycle is skipped so a just-issued unit can raise busy
                    if (cnt != '0 && units_idle) begin
                        sync_pls <= 1'b1;
                        state    <= IDLE;
                    end else if (cnt == CNT_W'(SYNC_TIMEOUT)) begin
                        err[1]   <= 1'b1;
                        sync_pls <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.inst_busy_o   = (state == HOLD) || (state == SYNC_WAIT);
    assign bus.weight_en_o   = weight_en;
    assign bus.matmul_en_o   = matmul_en;
    assign bus.act_en_o      = act_en;
    assign bus.weight_inst_o = weight_inst;
    assign bus.matmul_inst_o = matmul_inst;
    assign bus.act_inst_o    = act_inst;
    assign bus.sync_o        = sync_pls;
    assign bus.error_o       = err;
endmodule
